// File: rtl/rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module      : rob_multi_commit
// Description : Parametrised reorder buffer. It is a circular queue of
//               in-flight instructions with WB_PORTS writeback ports and
//               in-order commit of up to COMMIT_W entries per cycle. When a
//               mispredicted branch commits, every younger entry is flushed
//               and a fetch redirect is raised.
// Optional    : ROB_EXT_FLUSH_EN adds the ext_flush input. ext_flush clears
//               every entry and suppresses commit without raising redirect.
// Ports       : clk, rst_n (async assert, active low)
//               alloc_valid/alloc_rd/alloc_pc -> alloc_ready/alloc_tag
//               wb_valid/wb_tag/wb_data/wb_mispred/wb_target (packed per port)
//               commit_valid/commit_rd/commit_data/commit_tag (packed per slot,
//               slot 0 is the oldest)
//               redirect_valid/redirect_pc, count
//               ext_flush (only when ROB_EXT_FLUSH_EN is defined)
// Revision    : 1.0 - initial release
// ============================================================================
module rob_multi_commit #(
    parameter  int DEPTH    = 16,
    parameter  int DATA_W   = 32,
    parameter  int PC_W     = 32,
    parameter  int WB_PORTS = 3,
    parameter  int COMMIT_W = 2,
    localparam int TAG_W    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef ROB_EXT_FLUSH_EN
    input  logic                         ext_flush,
`endif
    input  logic                         alloc_valid,
    input  logic [4:0]                   alloc_rd,
    input  logic [PC_W-1:0]              alloc_pc,
    output logic                         alloc_ready,
    output logic [TAG_W-1:0]             alloc_tag,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
    input  logic [WB_PORTS-1:0]          wb_mispred,
    input  logic [WB_PORTS*PC_W-1:0]     wb_target,
    output logic [COMMIT_W-1:0]          commit_valid,
    output logic [COMMIT_W*5-1:0]        commit_rd,
    output logic [COMMIT_W*DATA_W-1:0]   commit_data,
    output logic [COMMIT_W*TAG_W-1:0]    commit_tag,
    output logic                         redirect_valid,
    output logic [PC_W-1:0]              redirect_pc,
    output logic [TAG_W:0]               count
);

    localparam int PTR_W = TAG_W + 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;

    // Per-entry control state (reset) and payload (not reset).
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_rdy;
    logic [DEPTH-1:0]  r_mispred;
    logic [4:0]        r_rd     [DEPTH];
    logic [DATA_W-1:0] r_data   [DEPTH];
    logic [PC_W-1:0]   r_target [DEPTH];

    logic                w_ext_flush;
    logic                w_full;
    logic                w_alloc_fire;
    logic                w_go;
    logic                w_redirect;
    logic [PC_W-1:0]     w_redirect_pc;
    logic [PTR_W-1:0]    w_ncommit;
    logic [COMMIT_W-1:0] w_cvalid;
    logic [TAG_W-1:0]    w_cidx   [COMMIT_W];
    logic [TAG_W-1:0]    w_wb_tag [WB_PORTS];

    // The pc has no consumer on the commit side; redirect targets come from
    // writeback, so the dispatched pc is not kept in the entry payload.
    logic w_unused_pc;
    assign w_unused_pc = ^alloc_pc;

`ifdef ROB_EXT_FLUSH_EN
    assign w_ext_flush = ext_flush;
`else
    assign w_ext_flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Occupancy and allocation. alloc_ready looks only at registered
    // state, so a commit in this cycle never frees space for this cycle's
    // allocation.
    // ------------------------------------------------------------------
    assign w_full = (r_tail[TAG_W-1:0] == r_head[TAG_W-1:0]) &&
                    (r_tail[TAG_W] != r_head[TAG_W]);

    assign alloc_ready  = ~w_full & ~w_redirect & ~w_ext_flush;
    assign alloc_tag    = r_tail[TAG_W-1:0];
    assign w_alloc_fire = alloc_valid & alloc_ready;
    assign count        = r_tail - r_head;

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            w_wb_tag[p] = wb_tag[p*TAG_W +: TAG_W];
        end
    end

    // ------------------------------------------------------------------
    // Commit selection. Slots are examined oldest first; the chain stops at
    // the first entry that is not valid & ready (slots past the tail are
    // never valid, since committed and flushed entries are cleared), and
    // right after a mispredicted entry so nothing younger than it retires.
    // ------------------------------------------------------------------
    always_comb begin
        w_go          = ~w_ext_flush;
        w_cvalid      = '0;
        w_ncommit     = '0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            w_cidx[i] = r_head[TAG_W-1:0] + TAG_W'(i);
            if (w_go && r_valid[w_cidx[i]] && r_rdy[w_cidx[i]]) begin
                w_cvalid[i] = 1'b1;
                w_ncommit   = w_ncommit + PTR_W'(1);
                if (r_mispred[w_cidx[i]]) begin
                    w_redirect    = 1'b1;
                    w_redirect_pc = r_target[w_cidx[i]];
                    w_go          = 1'b0;
                end
            end else begin
                w_go = 1'b0;
            end
        end
    end

    assign commit_valid   = w_cvalid;
    assign redirect_valid = w_redirect;
    assign redirect_pc    = w_redirect_pc;

    always_comb begin
        commit_rd   = '0;
        commit_data = '0;
        commit_tag  = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            commit_tag[i*TAG_W +: TAG_W]   = w_cidx[i];
            commit_rd[i*5 +: 5]            = r_rd[w_cidx[i]];
            commit_data[i*DATA_W +: DATA_W] = r_data[w_cidx[i]];
        end
    end

    // ------------------------------------------------------------------
    // Pointer and control-bit update. An external flush outranks a
    // commit-time mispredict; either one drops that cycle's allocation and
    // writebacks and leaves the ROB empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_valid   <= '0;
            r_rdy     <= '0;
            r_mispred <= '0;
        end else if (w_ext_flush) begin
            r_valid   <= '0;
            r_rdy     <= '0;
            r_mispred <= '0;
            r_tail    <= r_head;
        end else if (w_redirect) begin
            // The mispredicted slot is the last committed one, so
            // head + ncommit is exactly head + k + 1.
            r_valid   <= '0;
            r_rdy     <= '0;
            r_mispred <= '0;
            r_head    <= r_head + w_ncommit;
            r_tail    <= r_head + w_ncommit;
        end else begin
            if (w_alloc_fire) begin
                r_valid[r_tail[TAG_W-1:0]]   <= 1'b1;
                r_rdy[r_tail[TAG_W-1:0]]     <= 1'b0;
                r_mispred[r_tail[TAG_W-1:0]] <= 1'b0;
                r_tail                       <= r_tail + PTR_W'(1);
            end
            // Later ports overwrite earlier ones when tags collide.
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p] && r_valid[w_wb_tag[p]]) begin
                    r_rdy[w_wb_tag[p]]     <= 1'b1;
                    r_mispred[w_wb_tag[p]] <= wb_mispred[p];
                end
            end
            // Retiring entries are cleared last so a late writeback to an
            // entry that commits this cycle cannot keep it alive.
            for (int i = 0; i < COMMIT_W; i++) begin
                if (w_cvalid[i]) begin
                    r_valid[w_cidx[i]]   <= 1'b0;
                    r_rdy[w_cidx[i]]     <= 1'b0;
                    r_mispred[w_cidx[i]] <= 1'b0;
                end
            end
            r_head <= r_head + w_ncommit;
        end
    end

    // ------------------------------------------------------------------
    // Payload storage. Only meaningful while the entry is valid, so it
    // needs no reset; a write into an entry that is being flushed is
    // harmless because its control bits are cleared.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_rd[r_tail[TAG_W-1:0]] <= alloc_rd;
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && r_valid[w_wb_tag[p]]) begin
                r_data[w_wb_tag[p]]   <= wb_data[p*DATA_W +: DATA_W];
                r_target[w_wb_tag[p]] <= wb_target[p*PC_W +: PC_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_multi_commit
// Description : Self-checking bench for rob_multi_commit. A queue-level
//               reference model (head/tail as unbounded sequence numbers)
//               predicts commit, redirect and occupancy each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_multi_commit;

    localparam int DEPTH    = 16;
    localparam int DATA_W   = 32;
    localparam int PC_W     = 32;
    localparam int WB_PORTS = 3;
    localparam int COMMIT_W = 2;
    localparam int TAG_W    = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        ext_flush;
    logic                        alloc_valid;
    logic [4:0]                  alloc_rd;
    logic [PC_W-1:0]             alloc_pc;
    logic                        alloc_ready;
    logic [TAG_W-1:0]            alloc_tag;
    logic [WB_PORTS-1:0]         wb_valid;
    logic [WB_PORTS*TAG_W-1:0]   wb_tag;
    logic [WB_PORTS*DATA_W-1:0]  wb_data;
    logic [WB_PORTS-1:0]         wb_mispred;
    logic [WB_PORTS*PC_W-1:0]    wb_target;
    logic [COMMIT_W-1:0]         commit_valid;
    logic [COMMIT_W*5-1:0]       commit_rd;
    logic [COMMIT_W*DATA_W-1:0]  commit_data;
    logic [COMMIT_W*TAG_W-1:0]   commit_tag;
    logic                        redirect_valid;
    logic [PC_W-1:0]             redirect_pc;
    logic [TAG_W:0]              count;

    int n_cmp = 0;
    int n_bad = 0;

    rob_multi_commit #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W),
        .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef ROB_EXT_FLUSH_EN
        .ext_flush(ext_flush),
`endif
        .alloc_valid(alloc_valid),
        .alloc_rd(alloc_rd),
        .alloc_pc(alloc_pc),
        .alloc_ready(alloc_ready),
        .alloc_tag(alloc_tag),
        .wb_valid(wb_valid),
        .wb_tag(wb_tag),
        .wb_data(wb_data),
        .wb_mispred(wb_mispred),
        .wb_target(wb_target),
        .commit_valid(commit_valid),
        .commit_rd(commit_rd),
        .commit_data(commit_data),
        .commit_tag(commit_tag),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: entries live between sequence numbers m_head and
    // m_tail; an entry's tag is its sequence number modulo DEPTH.
    // ------------------------------------------------------------------
    int          m_head, m_tail;
    bit          m_rdy  [DEPTH];
    bit          m_mis  [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_data [DEPTH];
    logic [31:0] m_tgt  [DEPTH];

    logic [COMMIT_W-1:0]        e_cvalid;
    logic [COMMIT_W*TAG_W-1:0]  e_ctag, mk_tag;
    logic [COMMIT_W*5-1:0]      e_crd, mk_rd;
    logic [COMMIT_W*DATA_W-1:0] e_cdata, mk_data;
    logic                       e_redir, e_ready;
    logic [PC_W-1:0]            e_rpc;
    logic [TAG_W:0]             e_count;
    logic [TAG_W-1:0]           e_tag;
    int                         e_n;

    function automatic void model_eval();
        int occ;
        int e;
        occ = m_tail - m_head;
        e_cvalid = '0; e_ctag = '0; e_crd = '0; e_cdata = '0;
        mk_tag = '0; mk_rd = '0; mk_data = '0;
        e_redir = 1'b0; e_rpc = '0; e_n = 0;
        if (!ext_flush) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (i >= occ) break;
                e = (m_head + i) % DEPTH;
                if (!m_rdy[e]) break;
                e_cvalid[i] = 1'b1;
                e_n++;
                e_ctag[i*TAG_W +: TAG_W]    = TAG_W'(e);
                e_crd[i*5 +: 5]             = m_rd[e];
                e_cdata[i*DATA_W +: DATA_W] = m_data[e];
                mk_tag[i*TAG_W +: TAG_W]    = '1;
                mk_rd[i*5 +: 5]             = '1;
                mk_data[i*DATA_W +: DATA_W] = '1;
                if (m_mis[e]) begin
                    e_redir = 1'b1;
                    e_rpc   = m_tgt[e];
                    break;
                end
            end
        end
        e_count = (TAG_W+1)'(occ);
        e_ready = (occ < DEPTH) && !e_redir && !ext_flush;
        e_tag   = TAG_W'(m_tail % DEPTH);
    endfunction

    // Advance the model by one clock according to the current inputs,
    // then let the DUT take the same edge.
    task automatic tick();
        int n, occ, t, e;
        bit fire;
        model_eval();
        n    = e_n;
        occ  = m_tail - m_head;
        fire = alloc_valid && e_ready;
        if (ext_flush) begin
            m_tail = m_head;
        end else if (e_redir) begin
            m_head = m_head + n;
            m_tail = m_head;
        end else begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (wb_valid[p]) begin
                    t = int'(wb_tag[p*TAG_W +: TAG_W]);
                    if (((t - (m_head % DEPTH) + DEPTH) % DEPTH) < occ) begin
                        m_rdy[t]  = 1'b1;
                        m_mis[t]  = wb_mispred[p];
                        m_data[t] = wb_data[p*DATA_W +: DATA_W];
                        m_tgt[t]  = wb_target[p*PC_W +: PC_W];
                    end
                end
            end
            if (fire) begin
                e = m_tail % DEPTH;
                m_rdy[e] = 1'b0;
                m_mis[e] = 1'b0;
                m_rd[e]  = alloc_rd;
                m_tail++;
            end
            m_head = m_head + n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid   = '0;
        wb_mispred = '0;
    endtask

    task automatic set_wb(input int p, input int tag, input logic [31:0] data,
                          input bit mis, input logic [31:0] tgt);
        wb_valid[p]                  = 1'b1;
        wb_tag[p*TAG_W +: TAG_W]     = TAG_W'(tag);
        wb_data[p*DATA_W +: DATA_W]  = data;
        wb_mispred[p]                = mis;
        wb_target[p*PC_W +: PC_W]    = tgt;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        ext_flush   = 1'b0;
        clear_wb();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_head = 0;
        m_tail = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_rdy[i] = 1'b0;
            m_mis[i] = 1'b0;
        end
    endtask

    task automatic alloc_n(input int n);
        alloc_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            alloc_rd = 5'(m_tail + 1);
            alloc_pc = 32'h1000 + 32'(4 * m_tail);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b1;
        alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0; ext_flush = 1'b0;
        wb_tag = '0; wb_data = '0; wb_target = '0;
        clear_wb();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (alloc_ready !== 1'b1 || alloc_tag !== '0 || commit_valid !== '0 ||
            redirect_valid !== 1'b0 || count !== '0) begin
            n_bad++;
            $display("FAIL reset: ready=%b tag=%0d cv=%b redir=%b count=%0d, want 1 0 00 0 0",
                     alloc_ready, alloc_tag, commit_valid, redirect_valid, count);
        end
        do_reset();
    endtask

    task automatic test_fill();
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_rd = 5'(i + 1);
            alloc_pc = 32'h1000 + 32'(4 * i);
            #1;
            n_cmp++;
            if (alloc_tag !== TAG_W'(i) || alloc_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL fill_tag[%0d]: tag=%0d ready=%b, want tag=%0d ready=1",
                         i, alloc_tag, alloc_ready, i);
            end
            tick();
        end
        n_cmp++;
        if (alloc_ready !== 1'b0 || count !== 5'd16) begin
            n_bad++;
            $display("FAIL fill_full: ready=%b count=%0d, want 0 16", alloc_ready, count);
        end
        tick();   // alloc still requested while full: must be refused
        alloc_valid = 1'b0;
        n_cmp++;
        if (count !== 5'd16) begin
            n_bad++;
            $display("FAIL fill_refuse: count=%0d, want 16", count);
        end
    endtask

    // Continues from the full ROB left by test_fill.
    task automatic test_pair_commit();
        set_wb(0, 1, 32'hB1, 1'b0, 32'h0);
        set_wb(1, 0, 32'hA0, 1'b0, 32'h0);
        tick();
        clear_wb();
        alloc_valid = 1'b1;
        #1;
        n_cmp++;
        if (commit_valid !== 2'b11 || commit_tag !== 8'h10 ||
            commit_data !== {32'hB1, 32'hA0} || commit_rd !== {5'd2, 5'd1}) begin
            n_bad++;
            $display("FAIL pair_commit: cv=%b tag=%h data=%h rd=%h, want 11 10 000000b1000000a0 %h",
                     commit_valid, commit_tag, commit_data, commit_rd, {5'd2, 5'd1});
        end
        n_cmp++;
        if (alloc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL pair_full_ready: ready=%b, want 0", alloc_ready);
        end
        tick();
        alloc_valid = 1'b0;
        n_cmp++;
        if (count !== 5'd14 || commit_valid !== 2'b00 || alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
            n_bad++;
            $display("FAIL pair_after: count=%0d cv=%b ready=%b tag=%0d, want 14 00 1 0",
                     count, commit_valid, alloc_ready, alloc_tag);
        end
    endtask

    task automatic test_in_order();
        do_reset();
        alloc_n(2);
        set_wb(2, 1, 32'h11, 1'b0, 32'h0);
        tick();
        clear_wb();
        #1;
        n_cmp++;
        if (commit_valid !== 2'b00 || count !== 5'd2) begin
            n_bad++;
            $display("FAIL in_order_hold: cv=%b count=%0d, want 00 2", commit_valid, count);
        end
        set_wb(0, 0, 32'h10, 1'b0, 32'h0);
        tick();
        clear_wb();
        #1;
        n_cmp++;
        if (commit_valid !== 2'b11 || commit_tag !== 8'h10 || commit_data !== {32'h11, 32'h10}) begin
            n_bad++;
            $display("FAIL in_order_commit: cv=%b tag=%h data=%h, want 11 10 0000001100000010",
                     commit_valid, commit_tag, commit_data);
        end
        tick();
        n_cmp++;
        if (count !== 5'd0) begin
            n_bad++;
            $display("FAIL in_order_drain: count=%0d, want 0", count);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        alloc_n(4);
        set_wb(0, 0, 32'h5, 1'b1, 32'h40);
        set_wb(1, 1, 32'h6, 1'b0, 32'h0);
        set_wb(2, 2, 32'h7, 1'b0, 32'h0);
        tick();
        clear_wb();
        set_wb(0, 3, 32'h8, 1'b0, 32'h0);
        alloc_valid = 1'b1;
        alloc_rd    = 5'd9;
        #1;
        n_cmp++;
        if (commit_valid !== 2'b01 || redirect_valid !== 1'b1 || redirect_pc !== 32'h40 ||
            alloc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mispredict: cv=%b redir=%b pc=%h ready=%b, want 01 1 00000040 0",
                     commit_valid, redirect_valid, redirect_pc, alloc_ready);
        end
        tick();
        clear_wb();
        alloc_valid = 1'b0;
        #1;
        n_cmp++;
        if (count !== 5'd0 || alloc_tag !== 4'd1 || redirect_valid !== 1'b0 || commit_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL mispredict_after: count=%0d tag=%0d redir=%b cv=%b, want 0 1 0 00",
                     count, alloc_tag, redirect_valid, commit_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        alloc_n(3);
        set_wb(0, 0, 32'h99, 1'b0, 32'h0);
        tick();
        clear_wb();
        #1;
        n_cmp++;
        if (commit_valid !== 2'b01 || count !== 5'd3) begin
            n_bad++;
            $display("FAIL reset_mid_pre: cv=%b count=%0d, want 01 3", commit_valid, count);
        end
        rst_n = 1'b0;   // asserted mid-cycle, no clock edge needed
        #1;
        n_cmp++;
        if (commit_valid !== 2'b00 || count !== 5'd0 || alloc_tag !== 4'd0 || alloc_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid: cv=%b count=%0d tag=%0d ready=%b, want 00 0 0 1",
                     commit_valid, count, alloc_tag, alloc_ready);
        end
        do_reset();
    endtask

    task automatic test_wrap_random();
        int occ, total;
        total = 0;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            alloc_valid = ($urandom_range(0, 3) != 0);
            alloc_rd    = 5'($urandom);
            alloc_pc    = $urandom;
            occ = m_tail - m_head;
            for (int p = 0; p < WB_PORTS; p++) begin
                wb_valid[p] = ($urandom_range(0, 2) == 0);
                if (occ > 0 && $urandom_range(0, 7) != 0)
                    wb_tag[p*TAG_W +: TAG_W] = TAG_W'((m_head + $urandom_range(0, occ - 1)) % DEPTH);
                else
                    wb_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, DEPTH - 1));
                wb_data[p*DATA_W +: DATA_W] = $urandom;
                wb_mispred[p]               = ($urandom_range(0, 19) == 0);
                wb_target[p*PC_W +: PC_W]   = $urandom;
            end
            #1;
            model_eval();
            n_cmp++;
            if (commit_valid !== e_cvalid || (commit_tag & mk_tag) !== e_ctag) begin
                n_bad++;
                $display("FAIL rand_commit cyc%0d: cv=%b tag=%h, want %b %h",
                         cyc, commit_valid, commit_tag & mk_tag, e_cvalid, e_ctag);
            end
            n_cmp++;
            if ((commit_data & mk_data) !== e_cdata || (commit_rd & mk_rd) !== e_crd) begin
                n_bad++;
                $display("FAIL rand_payload cyc%0d: data=%h rd=%h, want %h %h",
                         cyc, commit_data & mk_data, commit_rd & mk_rd, e_cdata, e_crd);
            end
            n_cmp++;
            if (redirect_valid !== e_redir || (e_redir && redirect_pc !== e_rpc)) begin
                n_bad++;
                $display("FAIL rand_redirect cyc%0d: redir=%b pc=%h, want %b %h",
                         cyc, redirect_valid, redirect_pc, e_redir, e_rpc);
            end
            n_cmp++;
            if (count !== e_count || alloc_ready !== e_ready || alloc_tag !== e_tag) begin
                n_bad++;
                $display("FAIL rand_occupancy cyc%0d: count=%0d ready=%b tag=%0d, want %0d %b %0d",
                         cyc, count, alloc_ready, alloc_tag, e_count, e_ready, e_tag);
            end
            total += e_n;
            tick();
        end
        alloc_valid = 1'b0;
        clear_wb();
        n_cmp++;
        if (total < 3 * DEPTH) begin
            n_bad++;
            $display("FAIL rand_wrap_volume: committed=%0d, want >= %0d", total, 3 * DEPTH);
        end
    endtask

`ifdef ROB_EXT_FLUSH_EN
    task automatic test_ext_flush();
        do_reset();
        alloc_n(5);
        set_wb(0, 0, 32'h1, 1'b0, 32'h0);
        set_wb(1, 1, 32'h2, 1'b0, 32'h0);
        tick();
        clear_wb();
        ext_flush   = 1'b1;
        alloc_valid = 1'b1;
        #1;
        n_cmp++;
        if (commit_valid !== 2'b00 || redirect_valid !== 1'b0 || alloc_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ext_flush: cv=%b redir=%b ready=%b, want 00 0 0",
                     commit_valid, redirect_valid, alloc_ready);
        end
        tick();
        ext_flush   = 1'b0;
        alloc_valid = 1'b0;
        #1;
        n_cmp++;
        if (count !== 5'd0 || alloc_tag !== 4'd0 || commit_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL ext_flush_after: count=%0d tag=%0d cv=%b, want 0 0 00",
                     count, alloc_tag, commit_valid);
        end
        // ext_flush outranks a mispredict that would commit in the same cycle
        alloc_n(2);
        set_wb(0, 0, 32'h3, 1'b1, 32'h80);
        tick();
        clear_wb();
        ext_flush = 1'b1;
        #1;
        n_cmp++;
        if (redirect_valid !== 1'b0 || commit_valid !== 2'b00) begin
            n_bad++;
            $display("FAIL ext_flush_prio: redir=%b cv=%b, want 0 00", redirect_valid, commit_valid);
        end
        tick();
        ext_flush = 1'b0;
        #1;
        n_cmp++;
        if (count !== 5'd0 || alloc_tag !== 4'd0) begin
            n_bad++;
            $display("FAIL ext_flush_prio_after: count=%0d tag=%0d, want 0 0", count, alloc_tag);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_pair_commit();
        test_in_order();
        test_mispredict();
        test_reset_mid();
        test_wrap_random();
`ifdef ROB_EXT_FLUSH_EN
        test_ext_flush();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
